// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states,
// default bus timeout and the alignment rule used by the request path.
package mem_pkg;

  typedef enum logic [1:0] {
    MT_WORD     = 2'b00,
    MT_HALF     = 2'b01,
    MT_WORD_ALT = 2'b10,
    MT_BYTE     = 2'b11
  } mem_type_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Bytes are never misaligned; halves need addr[0]=0; words (both codes) need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] mem_type, input logic [1:0] addr_lo);
    logic mis;
    case (mem_type)
      MT_HALF: mis = addr_lo[0];
      MT_BYTE: mis = 1'b0;
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane steering: store byte enables and replication,
// plus half/byte extraction from a returned read word.
module lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  mem_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [3:0]  byte_en,
  output logic [31:0] store_lanes,
  output logic [15:0] load_half,
  output logic [7:0]  load_byte
);

  always_comb begin
    byte_en     = 4'b1111;
    store_lanes = store_data;
    case (mem_type)
      MT_HALF: begin
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{store_data[15:0]}};
      end
      MT_BYTE: begin
        byte_en     = 4'b0001 << addr_lo;
        store_lanes = {4{store_data[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_half = addr_lo[1] ? load_data[31:16] : load_data[15:0];
    case (addr_lo)
      2'd0:    load_byte = load_data[7:0];
      2'd1:    load_byte = load_data[15:8];
      2'd2:    load_byte = load_data[23:16];
      default: load_byte = load_data[31:24];
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data memory access unit with an IDLE/BUSY bus FSM and W-stage register.
// Optional bus-ack timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemTypeM,
  input  logic        LoadExtSignM,
  input  logic        MemtoRegM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic        Flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        StallM,
  output logic [1:0]  ErrM,
  output logic [31:0] ReadDataW,
  output logic [15:0] ReadDataHW,
  output logic [7:0]  ReadDataBW,
  output logic [1:0]  MemTypeW,
  output logic        LoadExtSignW,
  output logic        MemtoRegW,
  output logic [31:0] ALUOutW,
  output logic        ValidW
);

  state_t      state, state_next;
  logic [31:0] addr_r, wdata_r;
  logic [1:0]  type_r;
  logic        we_r, ext_r, m2r_r, flush_r, done;
  logic        mem_op, misaligned, start, timeout;
  logic [3:0]  be_lanes;
  logic [31:0] wdata_lanes;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;

  // The M register still holds a finished access for one cycle after the bus
  // completes (StallM covers the ack cycle); `done` stops it being reissued.
  assign mem_op     = (MemReadM | MemWriteM) & ~done;
  assign misaligned = is_misaligned(MemTypeM, ALUOutM[1:0]);
  assign start      = (state == S_IDLE) & mem_op & ~misaligned & ~Flush;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] busy_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != S_BUSY) busy_cnt <= '0;
    else                          busy_cnt <= busy_cnt + 8'd1;
  end

  assign timeout = (state == S_BUSY) & ~bus_ack & (busy_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_be     = 4'b0000;
    StallM     = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_BUSY;
      S_BUSY: if (bus_ack || timeout) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (!reset) begin
      case (state)
        S_IDLE: StallM = start;
        S_BUSY: begin
          bus_req = 1'b1;
          bus_we  = we_r;
          bus_be  = be_lanes;
          StallM  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus_addr  = {addr_r[31:2], 2'b00};
  assign bus_wdata = wdata_lanes;

  lane_align u_lane_align (
    .mem_type    (type_r),
    .addr_lo     (addr_r[1:0]),
    .store_data  (wdata_r),
    .load_data   (bus_rdata),
    .byte_en     (be_lanes),
    .store_lanes (wdata_lanes),
    .load_half   (rd_half),
    .load_byte   (rd_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r  <= '0;
      wdata_r <= '0;
      type_r  <= '0;
      we_r    <= 1'b0;
      ext_r   <= 1'b0;
      m2r_r   <= 1'b0;
      flush_r <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == S_BUSY) & (bus_ack | timeout);
      if (start) begin
        addr_r  <= ALUOutM;
        wdata_r <= WriteDataM;
        type_r  <= MemTypeM;
        we_r    <= MemWriteM;
        ext_r   <= LoadExtSignM;
        m2r_r   <= MemtoRegM;
        flush_r <= 1'b0;
      end else if (state == S_BUSY && Flush) begin
        flush_r <= 1'b1;
      end
    end
  end

  // W stage: a bus result on ack, a pass-through for non-memory ops, else a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      ReadDataW    <= '0;
      ReadDataHW   <= '0;
      ReadDataBW   <= '0;
      MemTypeW     <= '0;
      LoadExtSignW <= 1'b0;
      MemtoRegW    <= 1'b0;
      ALUOutW      <= '0;
      ValidW       <= 1'b0;
      ErrM         <= 2'b00;
    end else begin
      ValidW <= 1'b0;
      ErrM   <= 2'b00;
      if (state == S_BUSY) begin
        if (bus_ack) begin
          ValidW       <= ~(flush_r | Flush);
          ReadDataW    <= bus_rdata;
          ReadDataHW   <= rd_half;
          ReadDataBW   <= rd_byte;
          MemTypeW     <= type_r;
          LoadExtSignW <= ext_r;
          MemtoRegW    <= m2r_r;
          ALUOutW      <= addr_r;
        end else if (timeout) begin
          ErrM[1] <= 1'b1;
        end
      end else if (!(MemReadM || MemWriteM)) begin
        if (!Flush) begin
          ValidW       <= 1'b1;
          ALUOutW      <= ALUOutM;
          MemTypeW     <= MemTypeM;
          LoadExtSignW <= LoadExtSignM;
          MemtoRegW    <= MemtoRegM;
        end
      end else if (!done && !Flush && misaligned) begin
        ErrM[0] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: W sideband goes through a scoreboard
// queue, bus-side and data values are checked inline per scenario.
module tb_mem_access_unit;

  localparam int W = 36;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM, LoadExtSignM, MemtoRegM, Flush;
  logic [1:0]  MemTypeM;
  logic [31:0] ALUOutM, WriteDataM;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        StallM;
  logic [1:0]  ErrM;
  logic [31:0] ReadDataW, ALUOutW;
  logic [15:0] ReadDataHW;
  logic [7:0]  ReadDataBW;
  logic [1:0]  MemTypeW;
  logic        LoadExtSignW, MemtoRegW, ValidW;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v, act_v;
  logic [31:0]  last_rdata;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemTypeM(MemTypeM),
    .LoadExtSignM(LoadExtSignM), .MemtoRegM(MemtoRegM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .Flush(Flush),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .StallM(StallM), .ErrM(ErrM),
    .ReadDataW(ReadDataW), .ReadDataHW(ReadDataHW), .ReadDataBW(ReadDataBW),
    .MemTypeW(MemTypeW), .LoadExtSignW(LoadExtSignW), .MemtoRegW(MemtoRegW),
    .ALUOutW(ALUOutW), .ValidW(ValidW)
  );

  // ---------------- driver tasks ----------------
  task automatic set_nop();
    MemReadM = 1'b0; MemWriteM = 1'b0; MemTypeM = 2'b00; LoadExtSignM = 1'b0;
    MemtoRegM = 1'b0; ALUOutM = 32'h0; WriteDataM = 32'h0; Flush = 1'b0;
  endtask

  task automatic drive_m(input logic rd, input logic [1:0] typ, input logic [31:0] addr, input logic [31:0] wdata);
    MemReadM = rd; MemWriteM = !rd; MemTypeM = typ; LoadExtSignM = 1'b1;
    MemtoRegM = rd; ALUOutM = addr; WriteDataM = wdata; Flush = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    drive_m(1'b1, 2'b00, 32'h100, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b want=0", StallM); end
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL reset_bus_req got=%0b want=0", bus_req); end
    checks++; if ({bus_be, bus_we} !== 5'b0) begin failures++; $display("FAIL reset_be_we got=%b want=00000", {bus_be, bus_we}); end
    checks++; if ({ErrM, ValidW} !== 3'b0) begin failures++; $display("FAIL reset_err_valid got=%b want=000", {ErrM, ValidW}); end
    act_v = {ALUOutW, MemTypeW, LoadExtSignW, MemtoRegW};
    checks++; if (act_v !== '0) begin failures++; $display("FAIL reset_sideband got=%h want=0", act_v); end
    checks++; if ({ReadDataW, ReadDataHW, ReadDataBW} !== 56'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", {ReadDataW, ReadDataHW, ReadDataBW}); end
    set_nop();
    reset = 1'b0;
  endtask

  task automatic do_access(input string tag, input logic rd, input logic [1:0] typ,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                           input int ack_wait, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [15:0] exp_h, input logic [7:0] exp_b);
    int stalls = 0;
    @(negedge clk);
    drive_m(rd, typ, addr, wdata);
    exp_q.push_back({addr, typ, 1'b1, rd});
    #1;
    if (StallM) stalls++;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL %s_req_early got=%0b want=0", tag, bus_req); end
    @(negedge clk);
    if (StallM) stalls++;
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL %s_req got=%0b want=1", tag, bus_req); end
    checks++; if (bus_addr !== {addr[31:2], 2'b00}) begin failures++; $display("FAIL %s_addr got=%h want=%h", tag, bus_addr, {addr[31:2], 2'b00}); end
    checks++; if (bus_be !== exp_be) begin failures++; $display("FAIL %s_be got=%b want=%b", tag, bus_be, exp_be); end
    checks++; if (bus_we !== !rd) begin failures++; $display("FAIL %s_we got=%0b want=%0b", tag, bus_we, !rd); end
    if (!rd) begin
      checks++; if (bus_wdata !== exp_wdata) begin failures++; $display("FAIL %s_wdata got=%h want=%h", tag, bus_wdata, exp_wdata); end
    end
    for (int i = 0; i < ack_wait; i++) begin
      @(negedge clk);
      if (StallM) stalls++;
      checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL %s_req_hold got=%0b want=1", tag, bus_req); end
    end
    bus_ack = 1'b1; bus_rdata = rdata; last_rdata = rdata;
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = $urandom;
    checks++; if (ValidW !== 1'b1) begin failures++; $display("FAIL %s_validw got=%0b want=1", tag, ValidW); end
    if (ValidW === 1'b1) begin
      act_v = {ALUOutW, MemTypeW, LoadExtSignW, MemtoRegW};
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL %s_sb got=%h want=<empty queue>", tag, act_v); end
      else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin failures++; $display("FAIL %s_sb got=%h want=%h", tag, act_v, exp_v); end
      end
    end
    checks++; if (ReadDataW !== rdata) begin failures++; $display("FAIL %s_rdw got=%h want=%h", tag, ReadDataW, rdata); end
    checks++; if (ReadDataHW !== exp_h) begin failures++; $display("FAIL %s_rdh got=%h want=%h", tag, ReadDataHW, exp_h); end
    checks++; if (ReadDataBW !== exp_b) begin failures++; $display("FAIL %s_rdb got=%h want=%h", tag, ReadDataBW, exp_b); end
    checks++; if ({bus_req, bus_be, bus_we} !== 6'b0) begin failures++; $display("FAIL %s_bus_idle got=%b want=000000", tag, {bus_req, bus_be, bus_we}); end
    checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL %s_stall_release got=%0b want=0", tag, StallM); end
    checks++; if (stalls !== 2 + ack_wait) begin failures++; $display("FAIL %s_stall_cycles got=%0d want=%0d", tag, stalls, 2 + ack_wait); end
    @(negedge clk);
    set_nop();
    checks++; if ({bus_req, ValidW} !== 2'b00) begin failures++; $display("FAIL %s_no_reissue got=%b want=00", tag, {bus_req, ValidW}); end
  endtask

  task automatic test_back_to_back();
    localparam int N = 8;
    @(negedge clk);
    for (int i = 0; i <= N; i++) begin
      if (i > 0) begin
        checks++; if (ValidW !== 1'b1) begin failures++; $display("FAIL pass_validw got=%0b want=1", ValidW); end
        act_v = {ALUOutW, MemTypeW, LoadExtSignW, MemtoRegW};
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL pass_sb got=%h want=<empty queue>", act_v); end
        else begin
          exp_v = exp_q.pop_front();
          if (act_v !== exp_v) begin failures++; $display("FAIL pass_sb got=%h want=%h", act_v, exp_v); end
        end
      end
      if (i < N) begin
        set_nop();
        ALUOutM = $urandom; MemTypeM = 2'($urandom_range(0, 3));
        LoadExtSignM = 1'($urandom_range(0, 1)); MemtoRegM = 1'($urandom_range(0, 1));
        exp_q.push_back({ALUOutM, MemTypeM, LoadExtSignM, MemtoRegM});
        #1;
        checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL pass_stall got=%0b want=0", StallM); end
        @(negedge clk);
      end
    end
    set_nop();
  endtask

  task automatic test_misaligned();
    logic [1:0]  typs [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
    logic [31:0] addrs[4] = '{32'h3001, 32'h3002, 32'h2001, 32'h3003};
    logic        rds  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_m(rds[k], typs[k], addrs[k], 32'hFFFF_FFFF);
      #1;
      checks++; if ({StallM, bus_req} !== 2'b00) begin failures++; $display("FAIL mis%0d_stall_req got=%b want=00", k, {StallM, bus_req}); end
      @(negedge clk);
      set_nop();
      checks++; if (ErrM !== 2'b01) begin failures++; $display("FAIL mis%0d_err got=%b want=01", k, ErrM); end
      checks++; if ({ValidW, bus_req} !== 2'b00) begin failures++; $display("FAIL mis%0d_valid_req got=%b want=00", k, {ValidW, bus_req}); end
      @(negedge clk);
      checks++; if ({ErrM, bus_req} !== 3'b000) begin failures++; $display("FAIL mis%0d_err_pulse got=%b want=000", k, {ErrM, bus_req}); end
    end
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    drive_m(1'b1, 2'b00, 32'h4000, 32'h0);
    Flush = 1'b1;
    #1;
    checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL flush_idle_stall got=%0b want=0", StallM); end
    @(negedge clk);
    set_nop(); ALUOutM = 32'h55; Flush = 1'b1;
    checks++; if ({bus_req, ValidW, ErrM} !== 4'b0) begin failures++; $display("FAIL flush_idle_bubble got=%b want=0000", {bus_req, ValidW, ErrM}); end
    @(negedge clk);
    set_nop();
    checks++; if (ValidW !== 1'b0) begin failures++; $display("FAIL flush_alu_bubble got=%0b want=0", ValidW); end
  endtask

  task automatic test_flush_busy();
    @(negedge clk);
    drive_m(1'b1, 2'b00, 32'h4004, 32'h0);
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL flush_busy_req got=%0b want=1", bus_req); end
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    repeat (2) begin
      checks++; if ({bus_req, StallM} !== 2'b11) begin failures++; $display("FAIL flush_busy_hold got=%b want=11", {bus_req, StallM}); end
      @(negedge clk);
    end
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D; last_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus_ack = 1'b0;
    checks++; if (ValidW !== 1'b0) begin failures++; $display("FAIL flush_busy_validw got=%0b want=0", ValidW); end
    checks++; if (ReadDataW !== 32'h0BAD_F00D) begin failures++; $display("FAIL flush_busy_rdw got=%h want=0badf00d", ReadDataW); end
    checks++; if ({bus_req, StallM} !== 2'b00) begin failures++; $display("FAIL flush_busy_idle got=%b want=00", {bus_req, StallM}); end
    @(negedge clk);
    set_nop();
    checks++; if ({bus_req, ValidW} !== 2'b00) begin failures++; $display("FAIL flush_busy_after got=%b want=00", {bus_req, ValidW}); end
  endtask

  task automatic test_idle_ack();
    logic [31:0] held;
    held = last_rdata;
    @(negedge clk);
    set_nop(); ALUOutM = 32'h77;
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    bus_ack = 1'b0;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL idle_ack_req got=%0b want=0", bus_req); end
    checks++; if (ReadDataW !== held) begin failures++; $display("FAIL idle_ack_rdw got=%h want=%h", ReadDataW, held); end
    checks++; if ({ValidW, ALUOutW} !== {1'b1, 32'h77}) begin failures++; $display("FAIL idle_ack_pass got=%h want=%h", {ValidW, ALUOutW}, {1'b1, 32'h77}); end
  endtask

  task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    drive_m(1'b1, 2'b00, 32'h5000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({bus_req, StallM} !== 2'b11) begin failures++; $display("FAIL to_busy%0d got=%b want=11", i, {bus_req, StallM}); end
    end
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL to_req_drop got=%0b want=0", bus_req); end
    checks++; if (ErrM !== 2'b10) begin failures++; $display("FAIL to_err got=%b want=10", ErrM); end
    checks++; if ({ValidW, StallM} !== 2'b00) begin failures++; $display("FAIL to_valid_stall got=%b want=00", {ValidW, StallM}); end
    @(negedge clk);
    set_nop();
    checks++; if ({ErrM, bus_req} !== 3'b000) begin failures++; $display("FAIL to_err_pulse got=%b want=000", {ErrM, bus_req}); end
`else
    do_access("no_to", 1'b1, 2'b00, 32'h5000, 32'h0, 32'h0102_0304, 12, 4'b1111, 32'h0, 16'h0304, 8'h04);
    checks++; if (ErrM !== 2'b00) begin failures++; $display("FAIL no_to_err got=%b want=00", ErrM); end
`endif
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    drive_m(1'b1, 2'b00, 32'h6000, 32'h0);
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL rst_busy_req got=%0b want=1", bus_req); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({bus_req, StallM, ValidW} !== 3'b000) begin failures++; $display("FAIL rst_busy_abandon got=%b want=000", {bus_req, StallM, ValidW}); end
    set_nop();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL rst_busy_after got=%0b want=0", bus_req); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    last_rdata = 32'h0;
    test_reset();
    do_access("lb",  1'b1, 2'b11, 32'h1003, 32'h0,         32'hAABB_CCDD, 0, 4'b1000, 32'h0,         16'hAABB, 8'hAA);
    do_access("sh",  1'b0, 2'b01, 32'h2002, 32'h0000_1234, 32'h5566_7788, 1, 4'b1100, 32'h1234_1234, 16'h5566, 8'h66);
    do_access("sb",  1'b0, 2'b11, 32'h2001, 32'h0000_00AB, 32'h0000_0000, 0, 4'b0010, 32'hABAB_ABAB, 16'h0000, 8'h00);
    do_access("lw",  1'b1, 2'b00, 32'h3000, 32'h0,         32'hDEAD_BEEF, 2, 4'b1111, 32'h0,         16'hBEEF, 8'hEF);
    do_access("lh",  1'b1, 2'b01, 32'h3006, 32'h0,         32'h8001_7FFF, 1, 4'b1100, 32'h0,         16'h8001, 8'h01);
    do_access("sw",  1'b0, 2'b00, 32'h3008, 32'hCAFE_F00D, 32'h0000_0000, 0, 4'b1111, 32'hCAFE_F00D, 16'h0000, 8'h00);
    do_access("lw2", 1'b1, 2'b10, 32'h3004, 32'h0,         32'h1122_3344, 0, 4'b1111, 32'h0,         16'h3344, 8'h44);
    test_back_to_back();
    test_misaligned();
    test_flush_idle();
    test_flush_busy();
    test_idle_ack();
    test_timeout();
    test_reset_busy();
    do_access("post", 1'b1, 2'b11, 32'h7000, 32'h0, 32'h0000_005A, 0, 4'b0001, 32'h0, 16'h005A, 8'h5A);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d want=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
